// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: synchronizes asynchronous CPU strobes and serializes
// them into single-cycle VDP requests, buffering writes in a small FIFO.
module cpu_io_bridge #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk_w,
    input  logic       reset_n_w,
    input  logic       csrn_w,
    input  logic       cswn_w,
    input  logic [1:0] port_sel,
    input  logic [7:0] cd_in,
    output logic       vdp_req,
    output logic       vdp_wrt,
    output logic [1:0] vdp_adr,
    output logic [7:0] vdp_dbo,
    input  logic       vdp_ack,
    input  logic [7:0] vdp_dbi,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       overflow,
    output logic       timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [WW-1:0] TO_CNT   = WW'(ACK_TIMEOUT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT
    } state_t;

    state_t        state_q;
    logic [WW-1:0] wait_q;

    logic rd_s1_q, rd_s2_q, rd_s3_q;
    logic wr_s1_q, wr_s2_q, wr_s3_q;
    logic [1:0] settle_q;
    logic armed, wr_start, rd_start;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [9:0]    head;
    logic          fifo_empty, fifo_full, push, pop;

    logic       read_pend_q;
    logic [1:0] rd_port_q;

    // Edges are ignored until the synchronizers hold real samples,
    // so a strobe held low across reset release is not a start.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            rd_s1_q  <= 1'b1;
            rd_s2_q  <= 1'b1;
            rd_s3_q  <= 1'b1;
            wr_s1_q  <= 1'b1;
            wr_s2_q  <= 1'b1;
            wr_s3_q  <= 1'b1;
            settle_q <= 2'd0;
        end else begin
            rd_s1_q <= csrn_w;
            rd_s2_q <= rd_s1_q;
            rd_s3_q <= rd_s2_q;
            wr_s1_q <= cswn_w;
            wr_s2_q <= wr_s1_q;
            wr_s3_q <= wr_s2_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    assign armed    = (settle_q == 2'd3);
    assign wr_start = armed & wr_s3_q & ~wr_s2_q & rd_s2_q;
    assign rd_start = armed & rd_s3_q & ~rd_s2_q & wr_s2_q;

    assign head       = mem_q[rptr_q];
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign pop  = (state_q == WR_WAIT) & (vdp_ack | (wait_q == TO_CNT));
    assign push = wr_start & (~fifo_full | pop);

    always_ff @(posedge clk_w) begin
        if (push) begin
            mem_q[wptr_q] <= {port_sel, cd_in};
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (wr_start && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // A new read start wins over the clear so a late read is not lost.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            read_pend_q <= 1'b0;
            rd_port_q   <= 2'd0;
        end else if (rd_start) begin
            read_pend_q <= 1'b1;
            rd_port_q   <= port_sel;
        end else if (state_q == RD_REQ) begin
            read_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state_q <= IDLE;
            wait_q  <= '0;
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            vdp_adr <= 2'd0;
            vdp_dbo <= 8'd0;
            rd_data <= 8'd0;
            timeout <= 1'b0;
        end else begin
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= WR_REQ;
                        vdp_req <= 1'b1;
                        vdp_wrt <= 1'b1;
                        vdp_adr <= head[9:8];
                        vdp_dbo <= head[7:0];
                    end else if (read_pend_q) begin
                        state_q <= RD_REQ;
                        vdp_req <= 1'b1;
                        vdp_adr <= rd_port_q;
                    end
                end
                WR_REQ: begin
                    state_q <= WR_WAIT;
                    wait_q  <= '0;
                end
                WR_WAIT: begin
                    if (vdp_ack) begin
                        state_q <= IDLE;
                    end else if (wait_q == TO_CNT) begin
                        state_q <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_ONE;
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                    wait_q  <= '0;
                end
                RD_WAIT: begin
                    if (vdp_ack) begin
                        state_q <= IDLE;
                        rd_data <= vdp_dbi;
                    end else if (wait_q == TO_CNT) begin
                        state_q <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = ~fifo_empty | read_pend_q | (state_q != IDLE);

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: directed vectors, corner-case sequences and
// randomized bursts checked against a CPU-order request model.
module tb_cpu_io_bridge;

    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic       clk_w     = 1'b0;
    logic       reset_n_w = 1'b1;
    logic       csrn_w    = 1'b1;
    logic       cswn_w    = 1'b1;
    logic [1:0] port_sel  = 2'd0;
    logic [7:0] cd_in     = 8'd0;
    logic       vdp_ack   = 1'b0;
    logic [7:0] vdp_dbi   = 8'd0;
    logic       vdp_req, vdp_wrt, busy, overflow, timeout;
    logic [1:0] vdp_adr;
    logic [7:0] vdp_dbo, rd_data;

    cpu_io_bridge #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
        .clk_w(clk_w), .reset_n_w(reset_n_w),
        .csrn_w(csrn_w), .cswn_w(cswn_w),
        .port_sel(port_sel), .cd_in(cd_in),
        .vdp_req(vdp_req), .vdp_wrt(vdp_wrt),
        .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo),
        .vdp_ack(vdp_ack), .vdp_dbi(vdp_dbi),
        .rd_data(rd_data), .busy(busy),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk_w = ~clk_w;

    typedef struct packed {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] dbo;
    } req_t;

    typedef struct {
        bit         w;
        logic [1:0] p;
        logic [7:0] d;
        int         dly;
        logic [7:0] dbi;
        logic       e_wrt;
        logic [1:0] e_adr;
        logic [7:0] e_dbo;
        logic [7:0] e_rd;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    req_t log_q[$];
    time  req_tq[$];
    time  ack_tq[$];
    bit   ack_en  = 1'b1;
    int   ack_dly = 3;
    logic [7:0] dbi_val = 8'd0;
    bit   pend = 1'b0;
    int   acnt = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_w);
            #1;
        end
    endtask

    // VDP model: logs every request, answers ack_dly cycles later.
    initial begin
        forever begin
            @(negedge clk_w);
            vdp_ack = 1'b0;
            vdp_dbi = ~dbi_val;
            if (!reset_n_w) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    acnt++;
                    if (ack_en && acnt >= ack_dly) begin
                        vdp_ack = 1'b1;
                        vdp_dbi = dbi_val;
                        pend    = 1'b0;
                        ack_tq.push_back($time);
                    end
                end
                if (vdp_req) begin
                    log_q.push_back('{vdp_wrt, vdp_adr, vdp_dbo});
                    req_tq.push_back($time);
                    pend = 1'b1;
                    acnt = 0;
                end
            end
        end
    end

    task automatic clear_log();
        log_q.delete();
        req_tq.delete();
        ack_tq.delete();
    endtask

    task automatic apply_reset();
        reset_n_w = 1'b0;
        tick(2);
        reset_n_w = 1'b1;
        tick(4);
        clear_log();
    endtask

    task automatic strobe_wr(input logic [1:0] p, input logic [7:0] d,
                             input int lo, input int hi);
        port_sel = p;
        cd_in    = d;
        cswn_w   = 1'b0;
        tick(lo);
        cswn_w   = 1'b1;
        tick(hi);
    endtask

    task automatic strobe_rd(input logic [1:0] p, input int lo,
                             input int hi);
        port_sel = p;
        csrn_w   = 1'b0;
        tick(lo);
        csrn_w   = 1'b1;
        tick(hi);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        tick(4);
        while (busy && k < 400) begin
            tick();
            k++;
        end
        chk({nm, " idle"}, busy, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " req"}, vdp_req, 0);
        chk({nm, " wrt"}, vdp_wrt, 0);
        chk({nm, " adr"}, vdp_adr, 0);
        chk({nm, " dbo"}, vdp_dbo, 0);
        chk({nm, " rd_data"}, rd_data, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " ovf"}, overflow, 0);
        chk({nm, " tmo"}, timeout, 0);
    endtask

    initial begin
        vec_t tbl[7];
        req_t exp_q[$];
        logic [7:0] last_dbo, exp_rd, d;
        logic [1:0] p;
        int n;

        tbl[0] = '{1'b1, 2'd1, 8'h87, 3,  8'hEE, 1'b1, 2'd1, 8'h87, 8'h00};
        tbl[1] = '{1'b0, 2'd2, 8'h00, 2,  8'h3C, 1'b0, 2'd2, 8'h87, 8'h3C};
        tbl[2] = '{1'b1, 2'd3, 8'hFF, 1,  8'hEE, 1'b1, 2'd3, 8'hFF, 8'h3C};
        tbl[3] = '{1'b1, 2'd0, 8'h00, 6,  8'hEE, 1'b1, 2'd0, 8'h00, 8'h3C};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 14, 8'hA5, 1'b0, 2'd0, 8'h00, 8'hA5};
        tbl[5] = '{1'b0, 2'd1, 8'h00, 16, 8'h5A, 1'b0, 2'd1, 8'h00, 8'h5A};
        tbl[6] = '{1'b1, 2'd2, 8'hC3, 16, 8'hEE, 1'b1, 2'd2, 8'hC3, 8'h5A};

        #3 reset_n_w = 1'b0;
        #1 chk_zero("reset async");
        tick(2);
        reset_n_w = 1'b1;
        tick(4);
        clear_log();
        chk_zero("after reset");

        // single write, latency and busy release
        ack_dly  = 3;
        port_sel = 2'd1;
        cd_in    = 8'h87;
        cswn_w   = 1'b0;
        tick();
        cswn_w   = 1'b1;
        tick(2);
        chk("A early req", vdp_req, 0);
        tick();
        chk("A req", vdp_req, 1);
        chk("A wrt", vdp_wrt, 1);
        chk("A adr", vdp_adr, 1);
        chk("A dbo", vdp_dbo, 8'h87);
        tick();
        chk("A req pulse", vdp_req, 0);
        chk("A wrt low", vdp_wrt, 0);
        chk("A dbo hold", vdp_dbo, 8'h87);
        tick(2);
        chk("A busy at ack", busy, 1);
        tick();
        chk("A busy after ack", busy, 0);
        chk("A req count", log_q.size(), 1);

        // burst with ack withheld overflows the FIFO
        apply_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe_wr(2'd2, 8'h10 + 8'(i), 1, 2);
        end
        chk("B overflow", overflow, 1);
        ack_dly = 2;
        ack_en  = 1'b1;
        wait_idle("B");
        chk("B req count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("B req%0d", i), log_q[i],
                {1'b1, 2'd2, 8'h10 + 8'(i)});
        end
        chk("B timeout", timeout, 0);
        chk("B overflow sticky", overflow, 1);

        // write then read: read waits for the write ack
        apply_reset();
        ack_dly = 8;
        dbi_val = 8'hA5;
        strobe_wr(2'd0, 8'h55, 1, 2);
        strobe_rd(2'd0, 1, 2);
        wait_idle("C");
        chk("C req count", log_q.size(), 2);
        chk("C write req", log_q[0], {1'b1, 2'd0, 8'h55});
        chk("C read wrt", log_q[1].wrt, 0);
        chk("C read adr", log_q[1].adr, 0);
        chk("C read after ack", req_tq[1] > ack_tq[0], 1);
        chk("C rd_data", rd_data, 8'hA5);

        // timeout: no ack ever
        apply_reset();
        ack_en   = 1'b0;
        port_sel = 2'd3;
        cd_in    = 8'h3E;
        cswn_w   = 1'b0;
        tick();
        cswn_w   = 1'b1;
        tick(3);
        chk("D req", vdp_req, 1);
        tick(16);
        chk("D busy last wait", busy, 1);
        chk("D timeout early", timeout, 0);
        tick();
        chk("D busy end", busy, 0);
        chk("D timeout", timeout, 1);
        tick(5);
        chk("D req count", log_q.size(), 1);
        apply_reset();
        ack_en = 1'b1;

        // both strobes fall together
        csrn_w = 1'b0;
        cswn_w = 1'b0;
        tick(2);
        csrn_w = 1'b1;
        cswn_w = 1'b1;
        tick(10);
        chk("E req count", log_q.size(), 0);
        chk("E busy", busy, 0);
        chk("E overflow", overflow, 0);

        // reset in WR_WAIT with entries queued
        apply_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe_wr(2'(i), 8'h60 + 8'(i), 1, 2);
        end
        chk("F busy before reset", busy, 1);
        reset_n_w = 1'b0;
        #1 chk_zero("F async reset");
        tick(2);
        reset_n_w = 1'b1;
        ack_en    = 1'b1;
        clear_log();
        tick();
        chk_zero("F after release");
        tick(30);
        chk("F req count", log_q.size(), 0);
        chk("F busy", busy, 0);

        // write strobe held low through reset release
        cswn_w    = 1'b0;
        reset_n_w = 1'b0;
        tick(2);
        reset_n_w = 1'b1;
        tick(10);
        chk("G held low req", log_q.size(), 0);
        chk("G held low busy", busy, 0);
        cswn_w = 1'b1;
        tick(3);
        ack_dly = 2;
        strobe_wr(2'd1, 8'hC7, 1, 2);
        wait_idle("G");
        chk("G req count", log_q.size(), 1);
        chk("G req", log_q[0], {1'b1, 2'd1, 8'hC7});

        // directed vectors
        apply_reset();
        foreach (tbl[i]) begin
            clear_log();
            ack_dly = tbl[i].dly;
            dbi_val = tbl[i].dbi;
            if (tbl[i].w) begin
                strobe_wr(tbl[i].p, tbl[i].d, 2, 3);
            end else begin
                strobe_rd(tbl[i].p, 2, 3);
            end
            wait_idle($sformatf("V%0d", i));
            chk($sformatf("V%0d count", i), log_q.size(), 1);
            chk($sformatf("V%0d wrt", i), log_q[0].wrt, tbl[i].e_wrt);
            chk($sformatf("V%0d adr", i), log_q[0].adr, tbl[i].e_adr);
            chk($sformatf("V%0d dbo", i), log_q[0].dbo, tbl[i].e_dbo);
            chk($sformatf("V%0d rd_data", i), rd_data, tbl[i].e_rd);
            chk($sformatf("V%0d timeout", i), timeout, 0);
        end

        // random bursts: requests must appear in CPU order
        apply_reset();
        last_dbo = 8'd0;
        exp_rd   = 8'd0;
        for (int b = 0; b < 25; b++) begin
            clear_log();
            exp_q.delete();
            ack_dly = $urandom_range(1, 10);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                p = 2'($urandom_range(0, 3));
                d = 8'($urandom_range(0, 255));
                strobe_wr(p, d, $urandom_range(1, 3), $urandom_range(2, 4));
                exp_q.push_back('{1'b1, p, d});
                last_dbo = d;
            end
            if ($urandom_range(0, 1) == 1) begin
                p = 2'($urandom_range(0, 3));
                dbi_val = 8'($urandom_range(0, 255));
                strobe_rd(p, $urandom_range(1, 3), $urandom_range(2, 4));
                exp_q.push_back('{1'b0, p, last_dbo});
                exp_rd = dbi_val;
            end
            wait_idle($sformatf("R%0d", b));
            chk($sformatf("R%0d count", b), log_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                chk($sformatf("R%0d req%0d", b, i), log_q[i], exp_q[i]);
            end
            chk($sformatf("R%0d rd_data", b), rd_data, exp_rd);
        end
        chk("R overflow", overflow, 0);
        chk("R timeout", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
